sram_ctrl: RTL and testbench

Parametrised successor to the flat `sram` model used with `cpu`: a single-port synchronous word memory behind a req/ack handshake. It adds configurable depth and width, programmable wait states, out-of-range detection and optional per-word parity. It sits between `cpu` and the memory array and serves as the memory model in CPU-level benches.

---
 rtl/sram_ctrl_pkg.sv | 28 ++
 rtl/sram_array.sv | 62 ++++++
 rtl/sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared constants for the sram_ctrl memory model.
//   - FSM state encoding (IDLE/WAIT/RESP)
//   - default parameter values
//   - width of the wait-state counter (WAIT_CYCLES range 0..15)
//   - helper to size the storage index
package sram_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DEPTH       = 4096;
    localparam int DEF_WAIT_CYCLES = 1;

    // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
    localparam int WAIT_W = 4;

    // Index width for a storage of 'depth' words; never zero so that a
    // single-word memory still has a legal vector.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_array.sv
// sram_array: single-port word storage with synchronous write and
// registered read. Contents are never cleared by reset.
//
// Optional feature (macro SRAM_CTRL_PARITY_EN): each word carries one extra
// bit equal to ^data, captured on write; rmismatch flags a read whose
// recomputed parity disagrees with the stored bit. Without the macro there
// is no parity column and rmismatch is tied low.
//
// Ports:
//   clk       in   clock
//   we        in   write strobe (stores wdata at idx)
//   re        in   read strobe (loads rdata from idx on the same edge)
//   idx       in   word index
//   wdata     in   write data
//   rdata     out  registered read data
//   rmismatch out  parity mismatch for the word held in rdata
module sram_array
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int IDX_W      = idx_width(DEF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rmismatch
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

`ifdef SRAM_CTRL_PARITY_EN
    logic par_mem [DEPTH];
    logic rpar;

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[idx] <= ^wdata;
        end
        if (re) begin
            rpar <= par_mem[idx];
        end
    end

    assign rmismatch = (^rdata) != rpar;
`else
    assign rmismatch = 1'b0;
`endif

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port synchronous word memory behind a req/ack handshake,
// with programmable wait states, out-of-range detection and optional parity
// (macro SRAM_CTRL_PARITY_EN, see sram_array).
//
// Handshake: the requester raises req and holds req/we_n/addr/data_in
// stable until it sees ack. A request is accepted only at an edge where the
// FSM is IDLE; req in any other state is ignored and never queued. ack is a
// single-cycle strobe; err/perr/data_out are meaningful only while ack=1.
// Accept at edge t0 -> ack high in the cycle after edge t0+WAIT_CYCLES+1.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   req       in   transaction request
//   we_n      in   0 = write, 1 = read
//   addr      in   word address
//   data_in   in   write data
//   data_out  out  read data (0 after writes and errors, held otherwise)
//   ack       out  one-cycle completion strobe
//   err       out  address >= DEPTH, valid with ack
//   perr      out  parity mismatch on read, valid with ack
//   busy      out  high from the cycle after acceptance through the ack cycle
//   dbg_state out  current FSM state (ST_IDLE/ST_WAIT/ST_RESP)
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ack,
    output logic                  err,
    output logic                  perr,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = idx_width(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [WAIT_W-1:0]   WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    state_t                state;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we_n;
    logic [DATA_WIDTH-1:0] lat_data;

    logic                  accept;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we_n;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  cur_in_range;
    logic                  lat_in_range;

    logic                  arr_we;
    logic                  arr_re;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  arr_mismatch;

    assign dbg_state = state;
    assign accept    = (state == ST_IDLE) && req;

    // The storage access happens on the edge that enters RESP. With zero
    // wait states that is the accepting edge itself, before the inputs have
    // been latched, so the raw inputs are used while still in IDLE.
    always_comb begin
        commit = 1'b0;
        if (state == ST_IDLE) begin
            commit = req && (WAIT_CYCLES == 0);
        end else if (state == ST_WAIT) begin
            commit = (wait_cnt == '0);
        end
    end

    assign cur_addr     = (state == ST_IDLE) ? addr    : lat_addr;
    assign cur_we_n     = (state == ST_IDLE) ? we_n    : lat_we_n;
    assign cur_data     = (state == ST_IDLE) ? data_in : lat_data;
    assign cur_in_range = {1'b0, cur_addr} < DEPTH_LIM;
    assign lat_in_range = {1'b0, lat_addr} < DEPTH_LIM;

    // Out-of-range transactions never touch storage.
    assign arr_we = commit && !cur_we_n && cur_in_range;
    assign arr_re = commit &&  cur_we_n && cur_in_range;

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk        (clk),
        .we         (arr_we),
        .re         (arr_re),
        .idx        (cur_addr[IDX_W-1:0]),
        .wdata      (cur_data),
        .rdata      (arr_rdata),
        .rmismatch  (arr_mismatch)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            lat_addr <= '0;
            lat_we_n <= 1'b1;
            lat_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_addr <= addr;
                        lat_we_n <= we_n;
                        lat_data <= data_in;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Response registers are loaded from RESP, where the registered read
    // data is available, so ack lands in the cycle after RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            perr     <= 1'b0;
            busy     <= 1'b0;
            data_out <= '0;
        end else begin
            ack  <= (state == ST_RESP);
            busy <= accept || (state != ST_IDLE);
            if (state == ST_RESP) begin
                err      <= !lat_in_range;
                perr     <= lat_in_range && lat_we_n && arr_mismatch;
                data_out <= (lat_in_range && lat_we_n) ? arr_rdata : '0;
            end else begin
                err  <= 1'b0;
                perr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three sram_ctrl instances (WAIT_CYCLES = 0, 1, 3) checked
// against a word-array reference model. Parity behaviour follows
// SRAM_CTRL_PARITY_EN.
module tb_sram_ctrl;

    localparam int NI = 3;

    logic        clk;
    logic        reset_n;
    logic        req       [NI];
    logic        we_n      [NI];
    logic [15:0] addr      [NI];
    logic [15:0] data_in   [NI];
    logic [15:0] data_out  [NI];
    logic        ack       [NI];
    logic        err       [NI];
    logic        perr      [NI];
    logic        busy      [NI];
    logic [1:0]  dbg_state [NI];

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem   [NI][4096];
    bit          model_valid [NI][4096];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_ctrl #(
            .DATA_WIDTH  (16),
            .ADDR_WIDTH  (16),
            .DEPTH       (4096),
            .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .req       (req[g]),
            .we_n      (we_n[g]),
            .addr      (addr[g]),
            .data_in   (data_in[g]),
            .data_out  (data_out[g]),
            .ack       (ack[g]),
            .err       (err[g]),
            .perr      (perr[g]),
            .busy      (busy[g]),
            .dbg_state (dbg_state[g])
        );
    end

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete transaction on instance k, checked against the model.
    task automatic txn(input int k, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit exp_pe);
        int  n;
        int  w;
        bit  got_ack;
        bit  in_range;
        w        = wait_of(k);
        in_range = (a < 16'd4096);
        @(negedge clk);
        req[k]     = 1'b1;
        we_n[k]    = !wr;
        addr[k]    = a;
        data_in[k] = d;
        n       = 0;
        got_ack = 1'b0;
        while (!got_ack && n < 40) begin
            @(negedge clk);
            n++;
            if (ack[k]) got_ack = 1'b1;
            else check("busy_pending", busy[k], 1);
        end
        req[k] = 1'b0;
        check("latency", n, w + 2);
        if (got_ack) begin
            check("busy_at_ack", busy[k], 1);
            check("err", err[k], !in_range);
            check("perr", perr[k], exp_pe);
            if (wr || !in_range) begin
                check("data_zero", data_out[k], 0);
            end else if (model_valid[k][a[11:0]]) begin
                check("read_data", data_out[k], model_mem[k][a[11:0]]);
            end
            if (wr && in_range) begin
                model_mem[k][a[11:0]]   = d;
                model_valid[k][a[11:0]] = 1'b1;
            end
        end
        @(negedge clk);
        check("ack_one_cycle", ack[k], 0);
        check("busy_after", busy[k], 0);
    endtask

    initial begin
        logic [15:0] a;
        int          sel;

        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; we_n[k] = 1'b1; addr[k] = '0; data_in[k] = '0;
        end

        // reset values
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_ack", ack[k], 0);
            check("rst_err", err[k], 0);
            check("rst_perr", perr[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_data", data_out[k], 0);
            check("rst_state", dbg_state[k], 0);
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check("idle_ack", ack[k], 0);
                check("idle_busy", busy[k], 0);
            end
        end

        // basic write / read, one wait state
        txn(1, 1'b1, 16'h00A5, 16'h1234, 1'b0);
        txn(1, 1'b0, 16'h00A5, 16'h0000, 1'b0);

        // range boundary and out-of-range accesses
        txn(1, 1'b1, 16'h0000, 16'h5A5A, 1'b0);
        txn(1, 1'b1, 16'h0FFF, 16'hA5A5, 1'b0);
        txn(1, 1'b1, 16'h1000, 16'hFFFF, 1'b0);
        txn(1, 1'b0, 16'h1000, 16'h0000, 1'b0);
        txn(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        txn(1, 1'b0, 16'h0FFF, 16'h0000, 1'b0);

        // zero wait states: req held high gives ack every second cycle
        txn(0, 1'b1, 16'h0033, 16'hC0DE, 1'b0);
        @(negedge clk);
        req[0] = 1'b1; we_n[0] = 1'b1; addr[0] = 16'h0033;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("b2b_ack", ack[0], (n % 2) == 0);
            check("b2b_busy", busy[0], 1);
            if ((n % 2) == 0) check("b2b_data", data_out[0], 16'hC0DE);
        end
        req[0] = 1'b0;
        @(negedge clk);
        check("b2b_ack_end", ack[0], 0);
        check("b2b_busy_end", busy[0], 0);

        // reset during the wait phase of a write
        txn(2, 1'b1, 16'h0010, 16'h1111, 1'b0);
        @(negedge clk);
        req[2] = 1'b1; we_n[2] = 1'b0; addr[2] = 16'h0010; data_in[2] = 16'hBEEF;
        @(negedge clk);
        check("mid_wait_busy", busy[2], 1);
        reset_n = 1'b0;
        #1;
        check("rst_abort_busy", busy[2], 0);
        check("rst_abort_state", dbg_state[2], 0);
        req[2] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_abort_ack", ack[2], 0);
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_ack", ack[2], 0);
        end
        txn(2, 1'b0, 16'h0010, 16'h0000, 1'b0);

        // parity
`ifdef SRAM_CTRL_PARITY_EN
        txn(1, 1'b1, 16'h0005, 16'h0001, 1'b0);
        g_dut[1].u_dut.u_array.par_mem[5] = ~g_dut[1].u_dut.u_array.par_mem[5];
        txn(1, 1'b0, 16'h0005, 16'h0000, 1'b1);
`else
        txn(1, 1'b1, 16'h0005, 16'h0001, 1'b0);
        txn(1, 1'b0, 16'h0005, 16'h0000, 1'b0);
`endif

        // randomized traffic on every instance
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 25; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       a = 16'($urandom_range(0, 7));
                else if (sel == 7) a = 16'h0FFF;
                else if (sel == 8) a = 16'h1000;
                else               a = 16'($urandom_range(4097, 65535));
                txn(k, 1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
